// File: rtl/bus_master_ctrl_pkg.sv
// Shared bus definitions: word widths, bus direction and active-low levels,
// and the bus-master sequencer state encodings.
package bus_master_ctrl_pkg;

    localparam int WORD_ADDR_W = 30;
    localparam int WORD_DATA_W = 32;

    localparam logic READ  = 1'b1;
    localparam logic WRITE = 1'b0;

    localparam logic ENABLE_  = 1'b0;
    localparam logic DISABLE_ = 1'b1;

    localparam logic [1:0] BUS_IF_STATE_IDLE   = 2'd0;
    localparam logic [1:0] BUS_IF_STATE_REQ    = 2'd1;
    localparam logic [1:0] BUS_IF_STATE_ACCESS = 2'd2;
    localparam logic [1:0] BUS_IF_STATE_DONE   = 2'd3;

endpackage

// File: rtl/bus_master_ctrl.sv
// Bus-master sequencer: turns a one-cycle core request into req/grant/strobe/ready
// on one master port, with an ACCESS timeout and bus ownership kept across back-to-back transfers.
//
// state  | meaning
// IDLE   | bus released, waiting for core_req
// REQ    | m_req_ low, waiting for grant
// ACCESS | strobe issued, waiting for m_rdy_ or timeout
// DONE   | one cycle: done pulse out, bus still held
module bus_master_ctrl
    import bus_master_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYC = 256,
    parameter int TO_CNT_W    = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   core_req,
    input  logic [WORD_ADDR_W-1:0] core_addr,
    input  logic                   core_rw,
    input  logic [WORD_DATA_W-1:0] core_wr_data,
    output logic                   core_busy,
    output logic                   core_done,
    output logic [WORD_DATA_W-1:0] core_rd_data,
    output logic                   core_err,
    output logic                   m_req_,
    input  logic                   m_grnt_,
    output logic [WORD_ADDR_W-1:0] m_addr,
    output logic                   m_as_,
    output logic                   m_rw,
    output logic [WORD_DATA_W-1:0] m_wr_data,
    input  logic [WORD_DATA_W-1:0] m_rd_data,
    input  logic                   m_rdy_
);

    localparam logic [TO_CNT_W-1:0] TO_LAST = TO_CNT_W'(TIMEOUT_CYC - 1);

    logic [1:0]             state;
    logic [TO_CNT_W-1:0]    to_cnt;
    logic [WORD_ADDR_W-1:0] lat_addr;
    logic                   lat_rw;
    logic [WORD_DATA_W-1:0] lat_wr_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= BUS_IF_STATE_IDLE;
            to_cnt       <= '0;
            lat_addr     <= '0;
            lat_rw       <= READ;
            lat_wr_data  <= '0;
            core_busy    <= 1'b0;
            core_done    <= 1'b0;
            core_err     <= 1'b0;
            core_rd_data <= '0;
            m_req_       <= DISABLE_;
            m_as_        <= DISABLE_;
            m_addr       <= '0;
            m_rw         <= READ;
            m_wr_data    <= '0;
        end else begin
            core_done <= 1'b0;
            core_err  <= 1'b0;
            case (state)
                BUS_IF_STATE_IDLE: begin
                    if (core_req) begin
                        lat_addr    <= core_addr;
                        lat_rw      <= core_rw;
                        lat_wr_data <= core_wr_data;
                        m_req_      <= ENABLE_;
                        core_busy   <= 1'b1;
                        state       <= BUS_IF_STATE_REQ;
                    end
                end
                BUS_IF_STATE_REQ: begin
                    if (m_grnt_ == ENABLE_) begin
                        m_as_     <= ENABLE_;
                        m_addr    <= lat_addr;
                        m_rw      <= lat_rw;
                        m_wr_data <= lat_wr_data;
                        to_cnt    <= '0;
                        state     <= BUS_IF_STATE_ACCESS;
                    end
                end
                BUS_IF_STATE_ACCESS: begin
                    m_as_ <= DISABLE_;
                    // Ready is honoured even in the strobe cycle; timeout only when still not ready.
                    if (m_rdy_ == ENABLE_) begin
                        if (m_rw == READ) core_rd_data <= m_rd_data;
                        core_done <= 1'b1;
                        core_busy <= 1'b0;
                        state     <= BUS_IF_STATE_DONE;
                    end else if (to_cnt == TO_LAST) begin
                        core_done <= 1'b1;
                        core_err  <= 1'b1;
                        core_busy <= 1'b0;
                        state     <= BUS_IF_STATE_DONE;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                BUS_IF_STATE_DONE: begin
                    // A waiting request keeps m_req_ low so the bus is not re-arbitrated.
                    if (core_req) begin
                        lat_addr    <= core_addr;
                        lat_rw      <= core_rw;
                        lat_wr_data <= core_wr_data;
                        core_busy   <= 1'b1;
                        state       <= BUS_IF_STATE_REQ;
                    end else begin
                        m_req_ <= DISABLE_;
                        state  <= BUS_IF_STATE_IDLE;
                    end
                end
                default: state <= BUS_IF_STATE_IDLE;
            endcase
        end
    end

endmodule
